cpht_update_sched: RTL and testbench
====================================

// Module: cpht_update_sched
// PURPOSE
//  Deferred-update scheduler for the 256-entry choice PHT of the tournament BPU.
//  - Queues resolved branch outcomes from EX in an in-order FIFO.
//  - Drains each queued outcome as a read-modify-write of one 2-bit chooser counter.
//  - Shares the single PHT read port with fetch lookups; fetch always wins the port.
// PARAMETERS
//  IDX_W    8  PHT index width (256 entries)
//  Q_DEPTH  8  update FIFO entries (power of 2)
//  Q_AW     3  log2(Q_DEPTH)
// PORTS
//  clk          in   1      clock, rising edge
//  resetn       in   1      asynchronous active-low reset
//  stallreq     in   1      pipeline stall; blocks new PHT reads
//  upd_valid    in   1      EX resolved a conditional branch this cycle
//  upd_idx      in   IDX_W  PHT index used at predict time
//  upd_b_ok     in   1      bimodal component was correct
//  upd_g_ok     in   1      gshare component was correct
//  lk_req       in   1      fetch uses the PHT read port this cycle
//  pht_rd_en    out  1      updater read strobe
//  pht_rd_addr  out  IDX_W  updater read index
//  pht_rd_data  in   2      counter; valid the cycle after pht_rd_en
//  pht_wr_en    out  1      counter write strobe
//  pht_wr_addr  out  IDX_W  write index
//  pht_wr_data  out  2      new counter value
//  q_full       out  1      FIFO holds Q_DEPTH entries
//  q_count      out  Q_AW+1 FIFO occupancy
//  ovf_cnt      out  8      dropped-update counter, saturates at 8'hFF
// BEHAVIOUR
//  - Reset: all outputs 0; FIFO empty (rd_ptr = wr_ptr = 0); FSM in S_IDLE.
//  - Counter encoding: 00 strong-b, 01 weak-b, 10 weak-g, 11 strong-g.
//  - Enqueue filter:
//    - Enqueue only when upd_valid && (upd_b_ok != upd_g_ok).
//    - Store {idx, dir}, where dir = upd_g_ok.
//    - Agreeing outcomes are discarded silently and do not touch ovf_cnt.
//  - Enqueue while full without a same-cycle pop: entry dropped, ovf_cnt += 1 (saturating).
//  - Enqueue while full with a same-cycle pop: accepted; q_count stays at Q_DEPTH.
//  - Pointers are Q_AW bits and wrap modulo Q_DEPTH; q_count = entries held.
//  - FSM:
//    - S_IDLE: go to S_RD when the FIFO is non-empty (entry visible the cycle after its enqueue).
//    - S_RD:
//      - If !lk_req && !stallreq: drive pht_rd_en = 1 and pht_rd_addr = head idx, then go to S_WR.
//      - Otherwise hold in S_RD with pht_rd_en = 0.
//    - S_WR (one cycle, ignores stallreq and lk_req, never abandoned):
//      - Sample pht_rd_data.
//      - pht_wr_data = sat(cnt + 1) if dir = 1, else sat(cnt - 1).
//      - pht_wr_en = 1, pht_wr_addr = head idx.
//      - Pop the head.
//      - Next state: S_RD if the FIFO is still non-empty after the pop, else S_IDLE.
//  - Saturation: 11 + 1 stays 11; 00 - 1 stays 00. Write issued even when the value is unchanged.
//  - Throughput and ordering:
//    - At most one update per 2 cycles.
//    - Strictly FIFO order; no coalescing.
//    - Back-to-back updates to the same index are correct because the write lands before the next read.
//  - Minimum latency:
//    - Enqueue at cycle T, read at T+2, write at T+3 (idle, no lk_req, no stallreq).
//  - pht_rd_en and pht_wr_en are never asserted in the same cycle.
//  - pht_rd_addr and pht_wr_addr are 0 when their strobes are low.
//  - Asynchronous reset mid-RMW: the pending write is lost, the FIFO is cleared, and no strobe is issued after release.
//  - q_full = (q_count == Q_DEPTH).
// TESTING
//  - Single update:
//    - Stimulus: upd {idx=8'h3C, b_ok=0, g_ok=1}; pht_rd_data = 01.
//    - Response: rd_en at T+2 with addr 3C; wr_en at T+3 with addr 3C, data 10.
//  - Agree filter:
//    - Stimulus: upd {idx=8'h10, b_ok=1, g_ok=1} and {idx=8'h11, b_ok=0, g_ok=0}.
//    - Response: q_count stays 0, no strobes, ovf_cnt = 0.
//  - Saturation:
//    - Stimulus: dir=1 with rd_data = 11, then dir=0 with rd_data = 00.
//    - Response: wr_data 11, then 00.
//  - Port arbitration:
//    - Stimulus: lk_req held high 5 cycles with one entry queued.
//    - Response: no rd_en during those 5 cycles; rd_en in the first cycle lk_req = 0.
//  - Overflow:
//    - Stimulus: 10 disagreeing updates on consecutive cycles while stallreq = 1.
//    - Response: q_count = 8, q_full = 1, ovf_cnt = 2.
//    - Then drop stallreq: exactly 8 writes, in enqueue order.
//  - Reset mid-op:
//    - Stimulus: assert resetn = 0 in S_WR with 3 entries queued.
//    - Response: wr_en drops immediately, q_count = 0, no strobes after release.

Source files
------------

// File: rtl/cpht_update_sched.sv
// Deferred-update scheduler for the choice PHT: queues disagreeing branch outcomes
// and drains them one at a time as read-modify-writes of a 2-bit chooser counter.
module cpht_update_sched #(
   parameter int IDX_W   = 8,
   parameter int Q_DEPTH = 8,
   parameter int Q_AW    = 3
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             stallreq,
   input  logic             upd_valid,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_b_ok,
   input  logic             upd_g_ok,
   input  logic             lk_req,
   output logic             pht_rd_en,
   output logic [IDX_W-1:0] pht_rd_addr,
   input  logic [1:0]       pht_rd_data,
   output logic             pht_wr_en,
   output logic [IDX_W-1:0] pht_wr_addr,
   output logic [1:0]       pht_wr_data,
   output logic             q_full,
   output logic [Q_AW:0]    q_count,
   output logic [7:0]       ovf_cnt
);

   localparam logic [Q_AW:0]   CNT_FULL = (Q_AW+1)'(Q_DEPTH);
   localparam logic [Q_AW:0]   CNT_ONE  = (Q_AW+1)'(1);
   localparam logic [Q_AW-1:0] PTR_ONE  = Q_AW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [IDX_W:0]   mem_q [Q_DEPTH];
   logic [IDX_W:0]   mem_d [Q_DEPTH];
   logic [Q_AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [Q_AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [Q_AW:0]    count_q, count_d;
   logic [7:0]       ovf_q, ovf_d;

   logic             enq_req;
   logic             full;
   logic             pop;
   logic             push;
   logic             drop;
   logic [IDX_W:0]   head_entry;
   logic [IDX_W-1:0] head_idx;
   logic             head_dir;
   logic [1:0]       cnt_inc;
   logic [1:0]       cnt_dec;

   // Each entry is {idx, dir}; dir = 1 means gshare was the correct component.
   assign head_entry = mem_q[rd_ptr_q];
   assign head_idx   = head_entry[IDX_W:1];
   assign head_dir   = head_entry[0];
   assign full       = (count_q == CNT_FULL);

   // A pop in the same cycle frees a slot, so a push into a full queue still succeeds.
   always_comb begin
      enq_req  = upd_valid && (upd_b_ok != upd_g_ok);
      pop      = (state_q == S_WR);
      push     = enq_req && (!full || pop);
      drop     = enq_req && full && !pop;
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (push) begin
         mem_d[wr_ptr_q] = {upd_idx, upd_g_ok};
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push && !pop) begin
         count_d = count_q + CNT_ONE;
      end else if (pop && !push) begin
         count_d = count_q - CNT_ONE;
      end
      if (drop && (ovf_q != 8'hFF)) begin
         ovf_d = ovf_q + 8'd1;
      end
   end

   always_comb begin
      cnt_inc = (pht_rd_data == 2'b11) ? 2'b11 : (pht_rd_data + 2'b01);
      cnt_dec = (pht_rd_data == 2'b00) ? 2'b00 : (pht_rd_data - 2'b01);
   end

   // The write state never yields, so the port read issued in S_RD always completes.
   always_comb begin
      state_d     = state_q;
      pht_rd_en   = 1'b0;
      pht_rd_addr = '0;
      pht_wr_en   = 1'b0;
      pht_wr_addr = '0;
      pht_wr_data = 2'b00;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               state_d = S_RD;
            end
         end
         S_RD: begin
            if (!lk_req && !stallreq) begin
               pht_rd_en   = 1'b1;
               pht_rd_addr = head_idx;
               state_d     = S_WR;
            end
         end
         S_WR: begin
            pht_wr_en   = 1'b1;
            pht_wr_addr = head_idx;
            pht_wr_data = head_dir ? cnt_inc : cnt_dec;
            state_d     = (count_d != '0) ? S_RD : S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= '0;
         for (int i = 0; i < Q_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         for (int i = 0; i < Q_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign q_full  = full;
   assign q_count = count_q;
   assign ovf_cnt = ovf_q;

endmodule

// File: tb/tb_cpht_update_sched.sv
// Bench for cpht_update_sched: directed scenarios plus a random phase, all checked
// against a queue-and-array reference model of pending updates and PHT contents.
module tb_cpht_update_sched;

   localparam int IDX_W   = 8;
   localparam int Q_DEPTH = 8;
   localparam int Q_AW    = 3;

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic             stallreq = 1'b0;
   logic             upd_valid = 1'b0;
   logic [IDX_W-1:0] upd_idx = '0;
   logic             upd_b_ok = 1'b0;
   logic             upd_g_ok = 1'b0;
   logic             lk_req = 1'b0;
   logic             pht_rd_en;
   logic [IDX_W-1:0] pht_rd_addr;
   logic [1:0]       pht_rd_data = 2'b00;
   logic             pht_wr_en;
   logic [IDX_W-1:0] pht_wr_addr;
   logic [1:0]       pht_wr_data;
   logic             q_full;
   logic [Q_AW:0]    q_count;
   logic [7:0]       ovf_cnt;

   cpht_update_sched #(.IDX_W(IDX_W), .Q_DEPTH(Q_DEPTH), .Q_AW(Q_AW)) dut (
      .clk(clk), .resetn(resetn), .stallreq(stallreq), .upd_valid(upd_valid),
      .upd_idx(upd_idx), .upd_b_ok(upd_b_ok), .upd_g_ok(upd_g_ok), .lk_req(lk_req),
      .pht_rd_en(pht_rd_en), .pht_rd_addr(pht_rd_addr), .pht_rd_data(pht_rd_data),
      .pht_wr_en(pht_wr_en), .pht_wr_addr(pht_wr_addr), .pht_wr_data(pht_wr_data),
      .q_full(q_full), .q_count(q_count), .ovf_cnt(ovf_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] idx;
      logic       dir;
   } upd_t;

   int         testCount = 0;
   int         failCount = 0;
   logic [1:0] phtMem [256];
   logic [1:0] refPht [256];
   upd_t       refQ [$];
   int         expOvf = 0;
   logic [7:0] wrLog [$];
   logic       lastRdEn = 1'b0;
   logic       lastWrEn = 1'b0;
   logic       prevRdEn = 1'b0;
   logic [7:0] lastRdAddr = '0;
   logic [7:0] lastWrAddr = '0;
   logic [1:0] lastWrData = '0;
   int         strobeCount;

   // Reference rule for a chooser counter: step toward the correct component, clamped.
   function automatic logic [1:0] satStep(input logic [1:0] c, input logic dir);
      int v;
      v = int'(c) + (dir ? 1 : -1);
      if (v > 3) v = 3;
      if (v < 0) v = 0;
      return 2'(v);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] idx, input logic b,
                                input logic g, input logic lk, input logic st);
      upd_valid = v;
      upd_idx   = idx;
      upd_b_ok  = b;
      upd_g_ok  = g;
      lk_req    = lk;
      stallreq  = st;
   endtask

   // One clock: check outputs against the model mid-cycle, advance the model,
   // then let the PHT memory respond to the strobes at the rising edge.
   task automatic tick();
      int   sizeBefore;
      logic popped;
      upd_t e;
      logic [1:0] expData;
      @(negedge clk);
      sizeBefore = refQ.size();
      popped     = 1'b0;
      checkOutput("strobeExcl", 32'(pht_rd_en & pht_wr_en), 0);
      if (!pht_rd_en) checkOutput("rdAddrIdle", 32'(pht_rd_addr), 0);
      if (!pht_wr_en) checkOutput("wrAddrIdle", 32'(pht_wr_addr), 0);
      checkOutput("qCount", 32'(q_count), 32'(sizeBefore));
      checkOutput("qFull", 32'(q_full), 32'(sizeBefore == Q_DEPTH));
      checkOutput("ovfCnt", 32'(ovf_cnt), 32'(expOvf));
      if (pht_rd_en) begin
         checkOutput("rdPortFree", 32'(lk_req | stallreq), 0);
         checkOutput("rdHasEntry", 32'(sizeBefore != 0), 1);
         if (sizeBefore != 0) checkOutput("rdAddr", 32'(pht_rd_addr), 32'(refQ[0].idx));
      end
      if (pht_wr_en) begin
         checkOutput("wrAfterRd", 32'(prevRdEn), 1);
         checkOutput("wrHasEntry", 32'(sizeBefore != 0), 1);
         if (sizeBefore != 0) begin
            e       = refQ.pop_front();
            expData = satStep(refPht[e.idx], e.dir);
            checkOutput("wrAddr", 32'(pht_wr_addr), 32'(e.idx));
            checkOutput("wrData", 32'(pht_wr_data), 32'(expData));
            refPht[e.idx] = expData;
            popped = 1'b1;
         end
         wrLog.push_back(pht_wr_addr);
      end
      if (resetn && upd_valid && (upd_b_ok != upd_g_ok)) begin
         if (sizeBefore < Q_DEPTH || popped) refQ.push_back('{idx: upd_idx, dir: upd_g_ok});
         else if (expOvf < 255) expOvf++;
      end
      lastRdEn   = pht_rd_en;
      lastRdAddr = pht_rd_addr;
      lastWrEn   = pht_wr_en;
      lastWrAddr = pht_wr_addr;
      lastWrData = pht_wr_data;
      prevRdEn   = pht_rd_en;
      @(posedge clk);
      if (lastWrEn) phtMem[lastWrAddr] = lastWrData;
      if (lastRdEn) pht_rd_data = phtMem[lastRdAddr];
      #1;
   endtask

   task automatic waitForWrite(input string tag);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (lastWrEn) break;
      end
      checkOutput(tag, 32'(lastWrEn), 1);
   endtask

   task automatic setCounter(input logic [7:0] idx, input logic [1:0] val);
      phtMem[idx] = val;
      refPht[idx] = val;
   endtask

   initial begin
      logic d;
      for (int i = 0; i < 256; i++) begin
         phtMem[i] = 2'($urandom_range(0, 3));
         refPht[i] = phtMem[i];
      end

      // Reset state
      applyStimulus(0, 8'h00, 0, 0, 0, 0);
      #2;
      checkOutput("rstRdEn", 32'(pht_rd_en), 0);
      checkOutput("rstWrEn", 32'(pht_wr_en), 0);
      checkOutput("rstQCount", 32'(q_count), 0);
      checkOutput("rstQFull", 32'(q_full), 0);
      checkOutput("rstOvf", 32'(ovf_cnt), 0);
      tick();
      tick();
      resetn = 1'b1;
      tick();

      // Single update: minimum latency read at T+2, write at T+3
      setCounter(8'h3C, 2'b01);
      applyStimulus(1, 8'h3C, 0, 1, 0, 0);
      tick();
      applyStimulus(0, 8'h00, 0, 0, 0, 0);
      tick();
      checkOutput("singleT1RdEn", 32'(lastRdEn), 0);
      tick();
      checkOutput("singleT2RdEn", 32'(lastRdEn), 1);
      checkOutput("singleT2RdAddr", 32'(lastRdAddr), 32'h3C);
      tick();
      checkOutput("singleT3WrEn", 32'(lastWrEn), 1);
      checkOutput("singleT3WrAddr", 32'(lastWrAddr), 32'h3C);
      checkOutput("singleT3WrData", 32'(lastWrData), 32'h2);

      // Agreeing outcomes are filtered out
      strobeCount = 0;
      applyStimulus(1, 8'h10, 1, 1, 0, 0);
      tick();
      applyStimulus(1, 8'h11, 0, 0, 0, 0);
      tick();
      applyStimulus(0, 8'h00, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         strobeCount += int'(lastRdEn) + int'(lastWrEn);
      end
      checkOutput("agreeQCount", 32'(q_count), 0);
      checkOutput("agreeStrobes", 32'(strobeCount), 0);
      checkOutput("agreeOvf", 32'(ovf_cnt), 0);

      // Saturation at both ends
      setCounter(8'h20, 2'b11);
      setCounter(8'h21, 2'b00);
      applyStimulus(1, 8'h20, 0, 1, 0, 0);
      tick();
      applyStimulus(1, 8'h21, 1, 0, 0, 0);
      tick();
      applyStimulus(0, 8'h00, 0, 0, 0, 0);
      waitForWrite("satUpSeen");
      checkOutput("satUpData", 32'(lastWrData), 32'h3);
      waitForWrite("satDownSeen");
      checkOutput("satDownData", 32'(lastWrData), 32'h0);
      tick();

      // Fetch owns the read port while lk_req is high
      applyStimulus(1, 8'h55, 0, 1, 0, 0);
      tick();
      strobeCount = 0;
      applyStimulus(0, 8'h00, 0, 0, 1, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         strobeCount += int'(lastRdEn);
      end
      checkOutput("arbNoRd", 32'(strobeCount), 0);
      applyStimulus(0, 8'h00, 0, 0, 0, 0);
      tick();
      checkOutput("arbRdEn", 32'(lastRdEn), 1);
      checkOutput("arbRdAddr", 32'(lastRdAddr), 32'h55);
      tick();
      tick();

      // Overflow under stall, then in-order drain
      for (int i = 0; i < 10; i++) begin
         d = 1'(i % 2);
         applyStimulus(1, 8'(8'h40 + i), ~d, d, 0, 1);
         tick();
      end
      applyStimulus(0, 8'h00, 0, 0, 0, 1);
      tick();
      checkOutput("ovfQCount", 32'(q_count), 8);
      checkOutput("ovfQFull", 32'(q_full), 1);
      checkOutput("ovfCount", 32'(ovf_cnt), 2);
      wrLog.delete();
      applyStimulus(0, 8'h00, 0, 0, 0, 0);
      for (int i = 0; i < 40; i++) tick();
      checkOutput("ovfDrainWrites", 32'(wrLog.size()), 8);
      for (int i = 0; i < 8 && i < wrLog.size(); i++) begin
         checkOutput("ovfDrainOrder", 32'(wrLog[i]), 32'(8'h40 + i));
      end

      // Random traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 1) == 1, 8'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2);
         tick();
      end
      applyStimulus(0, 8'h00, 0, 0, 0, 0);
      for (int i = 0; i < 60; i++) tick();
      checkOutput("randDrainCount", 32'(q_count), 0);
      checkOutput("randDrainModel", 32'(refQ.size()), 0);

      // Asynchronous reset in the middle of a read-modify-write
      applyStimulus(1, 8'h70, 0, 1, 0, 1);
      tick();
      applyStimulus(1, 8'h71, 1, 0, 0, 1);
      tick();
      applyStimulus(1, 8'h72, 0, 1, 0, 1);
      tick();
      applyStimulus(0, 8'h00, 0, 0, 0, 1);
      tick();
      applyStimulus(0, 8'h00, 0, 0, 0, 0);
      tick();
      checkOutput("rstMidWrEn", 32'(pht_wr_en), 1);
      resetn = 1'b0;
      refQ.delete();
      expOvf   = 0;
      prevRdEn = 1'b0;
      #1;
      checkOutput("rstMidWrDrop", 32'(pht_wr_en), 0);
      checkOutput("rstMidQCount", 32'(q_count), 0);
      tick();
      resetn = 1'b1;
      strobeCount = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         strobeCount += int'(lastRdEn) + int'(lastWrEn);
      end
      checkOutput("rstMidNoStrobes", 32'(strobeCount), 0);
      checkOutput("rstMidQCountAfter", 32'(q_count), 0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
